load_sequencer: RTL and testbench

Multicycle load-path unit for the MIPS datapath: on a start pulse it issues a word-aligned memory read, waits a fixed memory latency, then selects the addressed byte, halfword or word from the returned data, sign- or zero-extends it to 32 bits and presents the result with a one-cycle done pulse for register write-back. It is the read-direction counterpart of the sub-word store-merge path and sits between the control unit, the memory and the write-back mux.

---
 rtl/load_pkg.sv | 31 +++
 rtl/load_sequencer_if.sv | 24 ++
 rtl/load_extract.sv | 38 +++
 rtl/load_sequencer.sv | 105 ++++++++++
 tb/tb_load_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/load_pkg.sv
// Shared definitions for the load path: ld_type codes, FSM state encoding
// and the alignment rule used by the sequencer.
package load_pkg;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_H  = 3'd1;
    localparam logic [2:0] LD_HU = 3'd2;
    localparam logic [2:0] LD_B  = 3'd3;
    localparam logic [2:0] LD_BU = 3'd4;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Codes 5..7 fall into the default arm and are treated as words.
    function automatic logic is_misaligned(input logic [2:0] ld_type, input logic [1:0] off);
        logic mis;
        case (ld_type)
            LD_H, LD_HU: mis = off[0];
            LD_B, LD_BU: mis = 1'b0;
            default:     mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_sequencer_if.sv
// Load-path bus: master is the outside world (control unit, memory, write-back),
// slave is the load sequencer.
interface load_sequencer_if;
    logic        start;
    logic [2:0]  ld_type;
    logic [31:0] addr;
    logic [31:0] mem_rdata;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] load_data;
    logic        done;
    logic        misalign;
    logic        busy;

    modport master (
        output start, ld_type, addr, mem_rdata,
        input  mem_rd, mem_addr, load_data, done, misalign, busy
    );

    modport slave (
        input  start, ld_type, addr, mem_rdata,
        output mem_rd, mem_addr, load_data, done, misalign, busy
    );
endinterface

// File: rtl/load_extract.sv
// Combinational sub-word select and sign/zero extension of a little-endian
// memory word; kept standalone so unaligned-load variants can reuse it.
module load_extract
    import load_pkg::*;
(
    input  logic [31:0] i_mem_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_ld_type,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_mem_rdata[7:0];
        case (i_off)
            2'd0:    w_byte = i_mem_rdata[7:0];
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            default: w_byte = i_mem_rdata[31:24];
        endcase
        // off[0] is deliberately ignored: the containing aligned halfword is used.
        w_half = i_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    end

    always_comb begin
        o_data = i_mem_rdata;
        case (i_ld_type)
            LD_H:    o_data = {{16{w_half[15]}}, w_half};
            LD_HU:   o_data = {16'h0000, w_half};
            LD_B:    o_data = {{24{w_byte[7]}}, w_byte};
            LD_BU:   o_data = {24'h000000, w_byte};
            default: o_data = i_mem_rdata;
        endcase
    end

endmodule

// File: rtl/load_sequencer.sv
// Multicycle load sequencer: word-aligned read, fixed memory latency, then
// sub-word extraction. Define LOAD_SEQ_MISALIGN_CHECK_EN to enable the ERR state.
module load_sequencer
    import load_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    load_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_addr;
    logic [2:0]         r_type;
    logic [31:0]        r_load_data;
    logic [31:0]        w_ext;
    logic               w_accept;

    assign w_accept = (r_state == ST_IDLE) && bus.start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
`ifdef LOAD_SEQ_MISALIGN_CHECK_EN
                    w_next = is_misaligned(bus.ld_type, bus.addr[1:0]) ? ST_ERR : ST_READ;
`else
                    w_next = ST_READ;
`endif
                end
            end
            ST_READ: begin
                if (r_cnt == '0) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_rd   = 1'b0;
        bus.done     = 1'b0;
        bus.misalign = 1'b0;
        bus.busy     = 1'b1;
        case (r_state)
            ST_IDLE: bus.busy   = 1'b0;
            ST_READ: bus.mem_rd = 1'b1;
            ST_DONE: bus.done   = 1'b1;
`ifdef LOAD_SEQ_MISALIGN_CHECK_EN
            ST_ERR:  bus.misalign = 1'b1;
`endif
            default: ;
        endcase
    end

    // Latency counter, latched request and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_addr      <= '0;
            r_type      <= '0;
            r_load_data <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= bus.addr;
                r_type <= bus.ld_type;
                r_cnt  <= CNT_INIT;
            end
            if (r_state == ST_READ) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end else begin
                    r_load_data <= w_ext;
                end
            end
        end
    end

    load_extract u_extract (
        .i_mem_rdata (bus.mem_rdata),
        .i_off       (r_addr[1:0]),
        .i_ld_type   (r_type),
        .o_data      (w_ext)
    );

    assign bus.mem_addr  = {r_addr[31:2], 2'b00};
    assign bus.load_data = r_load_data;

endmodule

// File: tb/tb_load_sequencer.sv
// Directed bench for load_sequencer: one instance with MEM_LAT=1, one with MEM_LAT=3.
module tb_load_sequencer;
    import load_pkg::*;

`ifdef LOAD_SEQ_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk;
    logic reset;

    load_sequencer_if if1 ();
    load_sequencer_if if3 ();

    load_sequencer #(.MEM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    load_sequencer #(.MEM_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        mem_rd;
        logic [31:0] mem_addr;
        logic [31:0] load_data;
        logic        done;
        logic        misalign;
        logic        busy;
    } out_t;

    typedef struct packed {
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        logic        mis;
    } vec_t;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic out_t get_out(input int which);
        out_t o;
        if (which == 1) begin
            o.mem_rd = if1.mem_rd; o.mem_addr = if1.mem_addr; o.load_data = if1.load_data;
            o.done = if1.done; o.misalign = if1.misalign; o.busy = if1.busy;
        end else begin
            o.mem_rd = if3.mem_rd; o.mem_addr = if3.mem_addr; o.load_data = if3.load_data;
            o.done = if3.done; o.misalign = if3.misalign; o.busy = if3.busy;
        end
        return o;
    endfunction

    task automatic set_in(input int which, input logic st, input logic [2:0] t,
                          input logic [31:0] a, input logic [31:0] d);
        if (which == 1) begin
            if1.start = st; if1.ld_type = t; if1.addr = a; if1.mem_rdata = d;
        end else begin
            if3.start = st; if3.ld_type = t; if3.addr = a; if3.mem_rdata = d;
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [2:0] t, input logic [31:0] a,
                                            input logic [31:0] d);
        logic [31:0] bsh;
        logic [31:0] hsh;
        bsh = d >> {a[1:0], 3'b000};
        hsh = d >> {a[1], 4'b0000};
        case (t)
            3'd1:    return {{16{hsh[15]}}, hsh[15:0]};
            3'd2:    return {16'h0000, hsh[15:0]};
            3'd3:    return {{24{bsh[7]}}, bsh[7:0]};
            3'd4:    return {24'h000000, bsh[7:0]};
            default: return d;
        endcase
    endfunction

    // Called at a falling edge with the DUT idle; returns at a falling edge with it idle.
    task automatic run_load(input int which, input int lat, input logic [2:0] t,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_data, input logic exp_mis,
                            input logic hammer, input string tag);
        out_t o;
        logic [31:0] al;
        al = {a[31:2], 2'b00};
        set_in(which, 1'b1, t, a, ~d);
        @(negedge clk);
        if (exp_mis) begin
            set_in(which, 1'b0, 3'd7, 32'hFFFF_FFFF, d);
            o = get_out(which);
            chk1({tag, " misalign"}, o.misalign, 1'b1);
            chk1({tag, " mem_rd in err"}, o.mem_rd, 1'b0);
            chk1({tag, " done in err"}, o.done, 1'b0);
            chk1({tag, " busy in err"}, o.busy, 1'b1);
            chk32({tag, " data kept"}, o.load_data, exp_data);
            @(negedge clk);
            o = get_out(which);
            chk1({tag, " misalign drop"}, o.misalign, 1'b0);
            chk1({tag, " idle after err"}, o.busy, 1'b0);
        end else begin
            for (int i = 0; i < lat; i++) begin
                set_in(which, hammer, hammer ? 3'd3 : 3'd7, 32'h0BAD_0BA0 ^ i,
                       (i == lat - 1) ? d : ~d);
                o = get_out(which);
                chk1($sformatf("%s mem_rd c%0d", tag, i), o.mem_rd, 1'b1);
                chk32($sformatf("%s mem_addr c%0d", tag, i), o.mem_addr, al);
                chk1($sformatf("%s early done c%0d", tag, i), o.done, 1'b0);
                chk1($sformatf("%s misalign c%0d", tag, i), o.misalign, 1'b0);
                @(negedge clk);
            end
            set_in(which, 1'b0, 3'd7, 32'hFFFF_FFFF, ~d);
            o = get_out(which);
            chk1({tag, " done"}, o.done, 1'b1);
            chk32({tag, " load_data"}, o.load_data, exp_data);
            chk1({tag, " mem_rd in done"}, o.mem_rd, 1'b0);
            chk1({tag, " misalign in done"}, o.misalign, 1'b0);
            @(negedge clk);
            o = get_out(which);
            chk1({tag, " done pulse"}, o.done, 1'b0);
            chk1({tag, " idle"}, o.busy, 1'b0);
            chk32({tag, " data held"}, o.load_data, exp_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t vt [14];
        vec_t bb [5];
        out_t o;

        vt[0]  = '{LD_B,  32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0};
        vt[1]  = '{LD_BU, 32'h0000_1003, 32'h80FF_1234, 32'h0000_0080, 1'b0};
        vt[2]  = '{LD_H,  32'h0000_2002, 32'h9ABC_0011, 32'hFFFF_9ABC, 1'b0};
        vt[3]  = '{LD_HU, 32'h0000_2000, 32'h9ABC_0011, 32'h0000_0011, 1'b0};
        vt[4]  = '{LD_W,  32'h0000_3001, 32'hCAFE_F00D,
                   MIS_EN ? 32'h0000_0011 : 32'hCAFE_F00D, MIS_EN};
        vt[5]  = '{LD_H,  32'h0000_2001, 32'h5555_A0B0,
                   MIS_EN ? 32'h0000_0011 : 32'hFFFF_A0B0, MIS_EN};
        vt[6]  = '{LD_HU, 32'h0000_2003, 32'h8001_7FFF,
                   MIS_EN ? 32'h0000_0011 : 32'h0000_8001, MIS_EN};
        vt[7]  = '{LD_B,  32'h0000_1001, 32'h80FF_1234, 32'h0000_0012, 1'b0};
        vt[8]  = '{LD_B,  32'h0000_1002, 32'h80FF_1234, 32'hFFFF_FFFF, 1'b0};
        vt[9]  = '{LD_BU, 32'h0000_1000, 32'h80FF_1234, 32'h0000_0034, 1'b0};
        vt[10] = '{LD_H,  32'h0000_2000, 32'h1234_8765, 32'hFFFF_8765, 1'b0};
        vt[11] = '{3'd5,  32'h0000_4000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vt[12] = '{3'd7,  32'h0000_4004, 32'h7FFF_0001, 32'h7FFF_0001, 1'b0};
        vt[13] = '{LD_HU, 32'h0000_2002, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0};

        bb[0] = '{LD_B,  32'h0000_5000, 32'h1122_3380, 32'h0, 1'b0};
        bb[1] = '{LD_BU, 32'h0000_5001, 32'h1122_F044, 32'h0, 1'b0};
        bb[2] = '{LD_H,  32'h0000_5002, 32'h8000_FFFF, 32'h0, 1'b0};
        bb[3] = '{LD_W,  32'h0000_5004, 32'h0F0F_0F0F, 32'h0, 1'b0};
        bb[4] = '{LD_B,  32'h0000_5003, 32'h7F00_0000, 32'h0, 1'b0};

        reset = 1'b1;
        set_in(1, 1'b0, 3'd0, 32'h0, 32'h0);
        set_in(3, 1'b0, 3'd0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        for (int w = 1; w <= 3; w += 2) begin
            o = get_out(w);
            chk1($sformatf("rst%0d mem_rd", w), o.mem_rd, 1'b0);
            chk1($sformatf("rst%0d busy", w), o.busy, 1'b0);
            chk1($sformatf("rst%0d done", w), o.done, 1'b0);
            chk1($sformatf("rst%0d misalign", w), o.misalign, 1'b0);
            chk32($sformatf("rst%0d load_data", w), o.load_data, 32'h0);
            chk32($sformatf("rst%0d mem_addr", w), o.mem_addr, 32'h0);
        end
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 14; k++) begin
            run_load(1, 1, vt[k].t, vt[k].a, vt[k].d, vt[k].exp, vt[k].mis, 1'b0,
                     $sformatf("vec%0d", k));
        end

        run_load(3, 3, LD_W, 32'h0000_3000, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 1'b1, "lw_lat3");

        // Abort a MEM_LAT=3 load in its second READ cycle.
        set_in(3, 1'b1, LD_W, 32'h0000_3000, 32'hAAAA_5555);
        @(negedge clk);
        set_in(3, 1'b0, LD_W, 32'h0000_3000, 32'hAAAA_5555);
        chk1("abort read1 mem_rd", get_out(3).mem_rd, 1'b1);
        @(negedge clk);
        chk1("abort read2 mem_rd", get_out(3).mem_rd, 1'b1);
        #1 reset = 1'b1;
        #1;
        o = get_out(3);
        chk1("abort mem_rd", o.mem_rd, 1'b0);
        chk1("abort busy", o.busy, 1'b0);
        chk1("abort done", o.done, 1'b0);
        chk32("abort load_data", o.load_data, 32'h0);
        chk32("abort mem_addr", o.mem_addr, 32'h0);
        chk32("abort dut1 load_data", get_out(1).load_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            o = get_out(3);
            chk1($sformatf("post-abort done c%0d", i), o.done, 1'b0);
            chk1($sformatf("post-abort busy c%0d", i), o.busy, 1'b0);
        end
        run_load(3, 3, LD_B, 32'h0000_3002, 32'h00AB_0000, 32'hFFFF_FFAB, 1'b0, 1'b0, "post_rst");

        // Back-to-back loads with start held high throughout.
        for (int k = 0; k < 5; k++) begin
            set_in(1, 1'b1, bb[k].t, bb[k].a, ~bb[k].d);
            @(negedge clk);
            o = get_out(1);
            chk1($sformatf("b2b%0d mem_rd", k), o.mem_rd, 1'b1);
            chk32($sformatf("b2b%0d mem_addr", k), o.mem_addr, {bb[k].a[31:2], 2'b00});
            set_in(1, 1'b1, 3'd1, 32'hFFFF_FFF1, bb[k].d);
            @(negedge clk);
            o = get_out(1);
            chk1($sformatf("b2b%0d done", k), o.done, 1'b1);
            chk32($sformatf("b2b%0d load_data", k), o.load_data,
                  ref_ext(bb[k].t, bb[k].a, bb[k].d));
            set_in(1, 1'b1, 3'd1, 32'hFFFF_FFF1, ~bb[k].d);
            @(negedge clk);
            o = get_out(1);
            chk1($sformatf("b2b%0d idle gap", k), o.busy, 1'b0);
            chk1($sformatf("b2b%0d done drop", k), o.done, 1'b0);
        end
        set_in(1, 1'b0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
